// File: rtl/ppu_scroll_pkg.sv
// Shared constants for the PPU scroll / VRAM address stage.
package ppu_scroll_pkg;

  localparam int V_W = 15;

  // CPU register selects seen by this stage.
  typedef enum logic [2:0] {
    RS_CTRL0  = 3'd0,
    RS_STATUS = 3'd2,
    RS_SCROLL = 3'd5,
    RS_ADDR   = 3'd6,
    RS_DATA   = 3'd7
  } rs_e;

  // Field slices of the VRAM address (V and T share the layout).
  localparam int FY_MSB = 14;
  localparam int FY_LSB = 12;
  localparam int NT_V   = 11;
  localparam int NT_H   = 10;
  localparam int CY_MSB = 9;
  localparam int CY_LSB = 5;
  localparam int CX_MSB = 4;
  localparam int CX_LSB = 0;

  // Last visible tile row; rows 30/31 hold attribute data.
  localparam logic [4:0] COARSE_Y_LAST = 5'd29;

endpackage

// File: rtl/ppu_vaddr_incr.sv
// Render-time update of V: coarse-X / Y increments and T->V copies.
module ppu_vaddr_incr
  import ppu_scroll_pkg::*;
(
  input  logic [14:0] v,
  input  logic [14:0] t,
  input  logic        inc_x,
  input  logic        inc_y,
  input  logic        copy_h,
  input  logic        copy_v,
  output logic [14:0] v_next
);

  logic [2:0] fy;
  logic [4:0] cy;
  logic [4:0] cx;

  assign fy = v[FY_MSB:FY_LSB];
  assign cy = v[CY_MSB:CY_LSB];
  assign cx = v[CX_MSB:CX_LSB];

  // Increments first, then copies, so a copy wins on any shared field.
  always_comb begin
    v_next = v;
    if (inc_x) begin
      if (cx == 5'd31) begin
        v_next[CX_MSB:CX_LSB] = '0;
        v_next[NT_H]          = ~v[NT_H];
      end else begin
        v_next[CX_MSB:CX_LSB] = cx + 5'd1;
      end
    end
    if (inc_y) begin
      if (fy != 3'd7) begin
        v_next[FY_MSB:FY_LSB] = fy + 3'd1;
      end else begin
        v_next[FY_MSB:FY_LSB] = '0;
        if (cy == COARSE_Y_LAST) begin
          v_next[CY_MSB:CY_LSB] = '0;
          v_next[NT_V]          = ~v[NT_V];
        end else if (cy == 5'd31) begin
          v_next[CY_MSB:CY_LSB] = '0;
        end else begin
          v_next[CY_MSB:CY_LSB] = cy + 5'd1;
        end
      end
    end
    if (copy_h) begin
      v_next[NT_H]          = t[NT_H];
      v_next[CX_MSB:CX_LSB] = t[CX_MSB:CX_LSB];
    end
    if (copy_v) begin
      v_next[FY_MSB:NT_V]   = t[FY_MSB:NT_V];
      v_next[CY_MSB:CY_LSB] = t[CY_MSB:CY_LSB];
    end
  end

endmodule

// File: rtl/ppu_scroll_vaddr.sv
// Scroll / VRAM address registers (T, V, fine X, write toggle W).
module ppu_scroll_vaddr #(
  parameter bit RD_INC = 1'b1,
  parameter int V_W    = ppu_scroll_pkg::V_W
) (
  input  logic           PCLK,
  input  logic           n_RES,
  input  logic           ACC,
  input  logic [2:0]     RS,
  input  logic           RnW,
  input  logic [7:0]     DB_in,
  input  logic           I_1_32,
  input  logic           RENDER_EN,
  input  logic           INC_X,
  input  logic           INC_Y,
  input  logic           COPY_H,
  input  logic           COPY_V,
  output logic [V_W-1:0] V,
  output logic [V_W-1:0] T,
  output logic [2:0]     FINE_X,
  output logic           W
);

  import ppu_scroll_pkg::*;

  rs_e            rs_sel;
  logic [V_W-1:0] t_d;
  logic [V_W-1:0] v_d;
  logic [V_W-1:0] v_render;
  logic [2:0]     fx_d;
  logic           w_d;
  logic           v_cpu;

  assign rs_sel = rs_e'(RS);

  ppu_vaddr_incr u_incr (
    .v      (V),
    .t      (T),
    .inc_x  (INC_X  & RENDER_EN),
    .inc_y  (INC_Y  & RENDER_EN),
    .copy_h (COPY_H & RENDER_EN),
    .copy_v (COPY_V & RENDER_EN),
    .v_next (v_render)
  );

  // CPU register decode; a CPU write of V suppresses the render update.
  always_comb begin
    t_d   = T;
    v_d   = V;
    fx_d  = FINE_X;
    w_d   = W;
    v_cpu = 1'b0;
    if (ACC) begin
      case (rs_sel)
        RS_CTRL0: begin
          if (!RnW) t_d[11:10] = DB_in[1:0];
        end
        RS_STATUS: begin
          if (RnW) w_d = 1'b0;
        end
        RS_SCROLL: begin
          if (!RnW) begin
            if (!W) begin
              t_d[4:0] = DB_in[7:3];
              fx_d     = DB_in[2:0];
              w_d      = 1'b1;
            end else begin
              t_d[14:12] = DB_in[2:0];
              t_d[9:5]   = DB_in[7:3];
              w_d        = 1'b0;
            end
          end
        end
        RS_ADDR: begin
          if (!RnW) begin
            if (!W) begin
              t_d[13:8] = DB_in[5:0];
              t_d[14]   = 1'b0;
              w_d       = 1'b1;
            end else begin
              t_d[7:0] = DB_in;
              w_d      = 1'b0;
              v_d      = t_d;
              v_cpu    = 1'b1;
            end
          end
        end
        RS_DATA: begin
          if (!RnW || RD_INC) begin
            v_d   = V + (I_1_32 ? V_W'(32) : V_W'(1));
            v_cpu = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (!v_cpu) v_d = v_render;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) begin
      T      <= '0;
      V      <= '0;
      FINE_X <= '0;
      W      <= 1'b0;
    end else begin
      T      <= t_d;
      V      <= v_d;
      FINE_X <= fx_d;
      W      <= w_d;
    end
  end

endmodule

// File: tb/tb_ppu_scroll_vaddr.sv
// Directed bench for ppu_scroll_vaddr.
module tb_ppu_scroll_vaddr;

  logic        PCLK = 1'b0;
  logic        n_RES;
  logic        ACC, RnW, I_1_32, RENDER_EN, INC_X, INC_Y, COPY_H, COPY_V;
  logic [2:0]  RS;
  logic [7:0]  DB_in;
  logic [14:0] V, T;
  logic [2:0]  FINE_X;
  logic        W;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ppu_scroll_vaddr #(.RD_INC(1'b1)) dut (
    .PCLK(PCLK), .n_RES(n_RES), .ACC(ACC), .RS(RS), .RnW(RnW), .DB_in(DB_in),
    .I_1_32(I_1_32), .RENDER_EN(RENDER_EN), .INC_X(INC_X), .INC_Y(INC_Y),
    .COPY_H(COPY_H), .COPY_V(COPY_V), .V(V), .T(T), .FINE_X(FINE_X), .W(W)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ACC = 0; RS = '0; RnW = 1'b1; DB_in = '0; I_1_32 = 0;
    RENDER_EN = 0; INC_X = 0; INC_Y = 0; COPY_H = 0; COPY_V = 0;
  endtask

  // One-cycle CPU access; returns on the following falling edge.
  task automatic cpu(input logic [2:0] rs, input logic rnw, input logic [7:0] db,
                     input logic step32);
    @(negedge PCLK);
    ACC = 1; RS = rs; RnW = rnw; DB_in = db; I_1_32 = step32;
    @(negedge PCLK);
    idle();
  endtask

  task automatic render(input logic en, input logic ix, input logic iy,
                        input logic ch, input logic cv);
    @(negedge PCLK);
    RENDER_EN = en; INC_X = ix; INC_Y = iy; COPY_H = ch; COPY_V = cv;
    @(negedge PCLK);
    idle();
  endtask

  initial begin
    idle();
    n_RES = 0;
    #3;
    check_eq("rst_T", T, 15'h0000);
    check_eq("rst_V", V, 15'h0000);
    @(negedge PCLK);
    n_RES = 1;

    // Build T=V=7FFF, W=1, then assert reset between edges.
    cpu(3'd5, 0, 8'hFF, 0);
    cpu(3'd5, 0, 8'hFF, 0);
    cpu(3'd0, 0, 8'h03, 0);
    render(1, 1, 1, 1, 1);
    cpu(3'd5, 0, 8'hFF, 0);
    check_eq("pre_T", T, 15'h7FFF);
    check_eq("pre_V", V, 15'h7FFF);
    check_eq("pre_W", {14'd0, W}, 15'd1);
    check_eq("pre_FX", {12'd0, FINE_X}, 15'd7);
    #2 n_RES = 0;
    #1;
    check_eq("arst_T", T, 15'h0000);
    check_eq("arst_V", V, 15'h0000);
    check_eq("arst_FX", {12'd0, FINE_X}, 15'd0);
    check_eq("arst_W", {14'd0, W}, 15'd0);
    @(negedge PCLK);
    n_RES = 1;

    // $2006 pair loads T then V.
    cpu(3'd6, 0, 8'h3F, 0);
    check_eq("a1_T", T, 15'h3F00);
    check_eq("a1_W", {14'd0, W}, 15'd1);
    check_eq("a1_V", V, 15'h0000);
    cpu(3'd6, 0, 8'h10, 0);
    check_eq("a2_T", T, 15'h3F10);
    check_eq("a2_W", {14'd0, W}, 15'd0);
    check_eq("a2_V", V, 15'h3F10);
    cpu(3'd7, 0, 8'h00, 1);
    check_eq("inc32_V", V, 15'h3F30);
    cpu(3'd7, 1, 8'h00, 0);
    check_eq("rdinc_V", V, 15'h3F31);
    check_eq("rdinc_T", T, 15'h3F10);
    cpu(3'd1, 0, 8'hFF, 0);
    check_eq("rs1_T", T, 15'h3F10);

    // $2005 pair.
    cpu(3'd5, 0, 8'h7D, 0);
    check_eq("s1_FX", {12'd0, FINE_X}, 15'd5);
    cpu(3'd5, 0, 8'h5E, 0);
    check_eq("s2_T", T, 15'h6D6F);
    check_eq("s2_W", {14'd0, W}, 15'd0);
    // Status read between writes resets the toggle.
    cpu(3'd5, 0, 8'h7D, 0);
    cpu(3'd2, 1, 8'h00, 0);
    check_eq("st_W", {14'd0, W}, 15'd0);
    cpu(3'd5, 0, 8'h5E, 0);
    check_eq("s3_T", T, 15'h6D6B);
    check_eq("s3_FX", {12'd0, FINE_X}, 15'd6);
    check_eq("s3_W", {14'd0, W}, 15'd1);
    cpu(3'd0, 0, 8'h02, 0);
    check_eq("ctl_T", T, 15'h696B);
    check_eq("ctl_W", {14'd0, W}, 15'd1);
    cpu(3'd2, 1, 8'h00, 0);

    // Coarse X wrap toggles NT horizontal.
    cpu(3'd6, 0, 8'h04, 0);
    cpu(3'd6, 0, 8'h1F, 0);
    check_eq("x_ld_V", V, 15'h041F);
    render(1, 1, 0, 0, 0);
    check_eq("xwrap_V", V, 15'h0000);

    // Fine Y 7, coarse Y 29 -> NT vertical toggle.
    cpu(3'd6, 0, 8'h33, 0);
    cpu(3'd6, 0, 8'hA0, 0);
    cpu(3'd5, 0, 8'h00, 0);
    cpu(3'd5, 0, 8'hEF, 0);
    check_eq("y29_T", T, 15'h73A0);
    render(1, 0, 0, 1, 1);
    check_eq("y29_V", V, 15'h73A0);
    render(1, 0, 1, 0, 0);
    check_eq("y29inc_V", V, 15'h0800);

    // Coarse Y 31 wraps without toggle.
    cpu(3'd5, 0, 8'h00, 0);
    cpu(3'd5, 0, 8'hFF, 0);
    render(1, 0, 0, 0, 1);
    check_eq("y31_V", V, 15'h73E0);
    render(1, 0, 1, 0, 0);
    check_eq("y31inc_V", V, 15'h0000);
    render(1, 0, 1, 0, 0);
    check_eq("fy_inc_V", V, 15'h1000);
    render(1, 1, 0, 0, 0);
    check_eq("cx_inc_V", V, 15'h1001);

    // Render disabled.
    render(0, 1, 1, 1, 1);
    check_eq("noren_V", V, 15'h1001);

    // CPU V increment overrides INC_X the same cycle.
    @(negedge PCLK);
    ACC = 1; RS = 3'd7; RnW = 0; I_1_32 = 1; RENDER_EN = 1; INC_X = 1;
    @(negedge PCLK);
    idle();
    check_eq("ovr_V", V, 15'h1021);

    // Copies override increments; then 7FFF + 1 wraps.
    cpu(3'd5, 0, 8'hFF, 0);
    cpu(3'd5, 0, 8'hFF, 0);
    cpu(3'd0, 0, 8'h03, 0);
    render(1, 1, 1, 1, 1);
    check_eq("cpovr_V", V, 15'h7FFF);
    cpu(3'd7, 0, 8'h00, 0);
    check_eq("wrap_V", V, 15'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
